// File: rtl/ccl_label_pkg.sv
// ccl_label_pkg: shared definitions for the connected-component labelling unit
//   label-width defaults, background/first label values, pixel classes,
//   and the {max,min} field layout of a merge-stack entry.
package ccl_label_pkg;

    localparam int LBL_WIDTH_DEF    = 8;
    localparam int STACK_DEPTH_DEF  = 16;
    localparam int CONNECTIVITY_DEF = 8;
    localparam int LBL_BG           = 0;
    localparam int LBL_FIRST        = 1;

    typedef enum logic [1:0] {PIX_BG, PIX_NEW, PIX_COPY, PIX_MERGE} pix_class_e;

    // A stack entry is a packed [1:0][LBL_WIDTH-1:0] pair: upper field max, lower field min.
    typedef enum logic {ENTRY_MIN = 1'b0, ENTRY_MAX = 1'b1} entry_field_e;

endpackage

// File: rtl/ccl_merge_stack.sv
// ccl_merge_stack: LIFO of pending label-equivalence entries
//   clk, reset     : clock, asynchronous active-high reset (empties the stack)
//   clear          : synchronous flush; a push in the same cycle lands in the empty stack
//   push, data_in  : push request and entry (dropped when full)
//   pop            : discard the top entry (ignored when empty)
//   data_out       : current top entry, valid while !empty
//   empty, full    : occupancy flags
module ccl_merge_stack
    import ccl_label_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH_DEF,
    parameter int WIDTH = 2 * LBL_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      cnt;
    logic [AW-1:0]    top;
    logic             swap;

    assign top      = cnt[AW-1:0] - AW'(1);
    assign empty    = cnt == '0;
    assign full     = cnt == (AW+1)'(DEPTH);
    assign data_out = mem[top];
    // push and pop together replace the top entry in place
    assign swap     = push && pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= (AW+1)'(push);
        else if (!swap && push && !full)
            cnt <= cnt + (AW+1)'(1);
        else if (!swap && pop && !empty)
            cnt <= cnt - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push && (clear || swap || !full))
            mem[clear ? '0 : swap ? top : cnt[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/ccl_label_unit.sv
// ccl_label_unit: first-pass provisional labelling with merge-table write-back
//   clk, reset          : clock, asynchronous active-high reset
//   en, sof, row_parity : pixel strobe, start of frame, y[0] of the pixel
//   A, B, C, D, p       : neighbour labels (above-left/centre/right, left), foreground bit
//   label_out/valid     : registered provisional label, one cycle after en
//   num_labels          : next label to issue
//   merge_wr_*          : merge-table write port (new label or popped equivalence)
//   exhausted           : sticky, label space ran out this frame
//   merge_overflow      : sticky, an equivalence was dropped this frame
module ccl_label_unit
    import ccl_label_pkg::*;
#(
    parameter int LBL_WIDTH    = LBL_WIDTH_DEF,
    parameter int STACK_DEPTH  = STACK_DEPTH_DEF,
    parameter int CONNECTIVITY = CONNECTIVITY_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 sof,
    input  logic                 row_parity,
    input  logic [LBL_WIDTH-1:0] A,
    input  logic [LBL_WIDTH-1:0] B,
    input  logic [LBL_WIDTH-1:0] C,
    input  logic [LBL_WIDTH-1:0] D,
    input  logic                 p,
    output logic [LBL_WIDTH-1:0] label_out,
    output logic                 label_valid,
    output logic [LBL_WIDTH-1:0] num_labels,
    output logic                 merge_wr_en,
    output logic [LBL_WIDTH-1:0] merge_wr_addr,
    output logic [LBL_WIDTH-1:0] merge_wr_data,
    output logic                 exhausted,
    output logic                 merge_overflow
);
    localparam logic [LBL_WIDTH-1:0] LBL_MAX = '1;
    localparam logic [LBL_WIDTH-1:0] BG      = LBL_WIDTH'(LBL_BG);
    localparam logic [LBL_WIDTH-1:0] FIRST   = LBL_WIDTH'(LBL_FIRST);

    logic [LBL_WIDTH-1:0]             nb [4];
    logic [LBL_WIDTH-1:0]             mn, mx, nl_eff, lbl;
    pix_class_e                       cls;
    logic                             start, cur_par, par_now, do_new, do_push, do_pop;
    logic [1:0]                       empty, full;
    logic [1:0][LBL_WIDTH-1:0]        push_entry, pop_entry;
    logic [1:0][1:0][LBL_WIDTH-1:0]   stk_out;

    // 4-connectivity ignores the diagonal neighbours
    assign nb[0] = CONNECTIVITY == 4 ? BG : A;
    assign nb[1] = B;
    assign nb[2] = CONNECTIVITY == 4 ? BG : C;
    assign nb[3] = D;

    always_comb begin
        mn = LBL_MAX;
        mx = BG;
        for (int i = 0; i < 4; i++) begin
            mn = (nb[i] != BG && nb[i] < mn) ? nb[i] : mn;
            mx = (nb[i] > mx) ? nb[i] : mx;
        end
    end

    assign cls     = !p ? PIX_BG : mx == BG ? PIX_NEW : mn == mx ? PIX_COPY : PIX_MERGE;
    assign start   = en && sof;
    assign nl_eff  = start ? FIRST : num_labels;
    assign lbl     = cls == PIX_BG ? BG : cls == PIX_NEW ? nl_eff : mn;
    assign do_new  = en && cls == PIX_NEW;
    assign do_push = en && cls == PIX_MERGE;

    // The stack being filled follows the current row; the other one drains.
    // Between pixels the last seen parity stands in for row_parity.
    assign par_now = en ? row_parity : cur_par;
    // A pop yields to a new-label write (stalled, not lost) and to a frame start.
    assign do_pop  = !empty[!par_now] && !start && !do_new;

    assign push_entry[ENTRY_MAX] = mx;
    assign push_entry[ENTRY_MIN] = mn;
    assign pop_entry             = stk_out[!par_now];

    for (genvar g = 0; g < 2; g++) begin : g_stk
        ccl_merge_stack #(
            .DEPTH(STACK_DEPTH),
            .WIDTH(2 * LBL_WIDTH)
        ) u_stk (
            .clk     (clk),
            .reset   (reset),
            .clear   (start),
            .push    (do_push && row_parity == 1'(g)),
            .pop     (do_pop && par_now != 1'(g)),
            .data_in (push_entry),
            .data_out(stk_out[g]),
            .empty   (empty[g]),
            .full    (full[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            label_out      <= BG;
            label_valid    <= 1'b0;
            num_labels     <= FIRST;
            merge_wr_en    <= 1'b0;
            merge_wr_addr  <= '0;
            merge_wr_data  <= '0;
            exhausted      <= 1'b0;
            merge_overflow <= 1'b0;
            cur_par        <= 1'b0;
        end else begin
            label_valid <= en;
            merge_wr_en <= do_new || do_pop;
            if (en) begin
                label_out  <= lbl;
                cur_par    <= row_parity;
                num_labels <= (do_new && nl_eff != LBL_MAX) ? nl_eff + LBL_WIDTH'(1) : nl_eff;
            end
            if (do_new || do_pop) begin
                merge_wr_addr <= do_new ? nl_eff : pop_entry[ENTRY_MAX];
                merge_wr_data <= do_new ? nl_eff : pop_entry[ENTRY_MIN];
            end
            // the top label is still issued once normally; reaching it marks the space used up
            exhausted      <= (exhausted && !start) || (do_new && nl_eff == LBL_MAX);
            merge_overflow <= (merge_overflow && !start) || (do_push && !start && full[row_parity]);
        end
    end

endmodule
